// File: rtl/bp_static_bht_if.sv
// Predictor port bundle: fetch-side prediction
// request/response plus the execute-side resolve port.
interface bp_static_bht_if #(
  parameter int unsigned ADDR_W = 64
);
  logic [ADDR_W-1:0] pc;
  logic [31:0]       instruction;
  logic              update_valid;
  logic [ADDR_W-1:0] update_pc;
  logic              update_taken;
  logic [ADDR_W-1:0] next_pc;
  logic              overwrite_pc;

  modport master (
    output pc,
    output instruction,
    output update_valid,
    output update_pc,
    output update_taken,
    input  next_pc,
    input  overwrite_pc
  );

  modport slave (
    input  pc,
    input  instruction,
    input  update_valid,
    input  update_pc,
    input  update_taken,
    output next_pc,
    output overwrite_pc
  );
endinterface

// File: rtl/bp_static_bht.sv
// Static JAL decode plus a direct-mapped 2-bit BHT
// for conditional branches; combinational predict.
module bp_static_bht #(
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned ADDR_W      = 64
) (
  input logic          clk,
  input logic          reset,
  bp_static_bht_if.slave bp
);
  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  logic [1:0] ctr_q [BHT_ENTRIES];
  logic [1:0] ctr_d [BHT_ENTRIES];

  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [1:0]        rd_ctr;
  logic [6:0]        opcode;
  logic              is_jal;
  logic              is_br;
  logic              br_taken;
  logic [20:0]       j_imm;
  logic [12:0]       b_imm;
  logic [ADDR_W-1:0] j_off;
  logic [ADDR_W-1:0] b_off;
  logic [ADDR_W-1:0] pc_seq;
  logic              unused_upc;

  assign rd_idx = bp.pc[IDX_W+1:2];
  assign wr_idx = bp.update_pc[IDX_W+1:2];
  assign rd_ctr = ctr_q[rd_idx];

  assign unused_upc = ^{bp.update_pc[ADDR_W-1:IDX_W+2],
                        bp.update_pc[1:0]};

  assign opcode   = bp.instruction[6:0];
  assign is_jal   = (opcode == OP_JAL);
  assign is_br    = (opcode == OP_BR);
  assign br_taken = rd_ctr[1];

  assign j_imm = {bp.instruction[31],
                  bp.instruction[19:12],
                  bp.instruction[20],
                  bp.instruction[30:21],
                  1'b0};
  assign b_imm = {bp.instruction[31],
                  bp.instruction[7],
                  bp.instruction[30:25],
                  bp.instruction[11:8],
                  1'b0};

  assign j_off  = {{(ADDR_W-21){j_imm[20]}}, j_imm};
  assign b_off  = {{(ADDR_W-13){b_imm[12]}}, b_imm};
  assign pc_seq = bp.pc + ADDR_W'(4);

  // Saturating counter training from the resolve port
  always_comb begin
    ctr_d = ctr_q;
    if (bp.update_valid) begin
      if (bp.update_taken) begin
        if (ctr_q[wr_idx] != 2'b11)
          ctr_d[wr_idx] = ctr_q[wr_idx] + 2'b01;
      end else begin
        if (ctr_q[wr_idx] != 2'b00)
          ctr_d[wr_idx] = ctr_q[wr_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++)
        ctr_q[i] <= 2'b01;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  // Reads see ctr_q, so same-cycle updates are not visible yet
  always_comb begin
    bp.next_pc      = pc_seq;
    bp.overwrite_pc = 1'b0;
    if (!reset) begin
      unique case (1'b1)
        is_jal: begin
          bp.next_pc      = bp.pc + j_off;
          bp.overwrite_pc = 1'b1;
        end
        is_br && br_taken: begin
          bp.next_pc      = bp.pc + b_off;
          bp.overwrite_pc = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bp_static_bht.sv
// Directed-vector bench for bp_static_bht with
// hand-computed next_pc / overwrite_pc expectations.
module tb_bp_static_bht;
  localparam logic [31:0] I_JAL16 = 32'h0100006F;
  localparam logic [31:0] I_JALM4 = 32'hFFDFF06F;
  localparam logic [31:0] I_BEQM8 = 32'hFE000CE3;
  localparam logic [31:0] I_BEQ16 = 32'h00000863;
  localparam logic [31:0] I_ADDI  = 32'h00000013;
  localparam logic [31:0] I_JALR  = 32'h00008067;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  bp_static_bht_if #(.ADDR_W(64)) bp ();

  bp_static_bht #(
    .BHT_ENTRIES(64),
    .ADDR_W     (64)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bp   (bp.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic pred(input string tag,
                      input logic [63:0] pc,
                      input logic [31:0] inst,
                      input logic [63:0] exp_npc,
                      input logic        exp_ow);
    bp.pc          = pc;
    bp.instruction = inst;
    #1;
    check({tag, ".npc"}, bp.next_pc, exp_npc);
    check({tag, ".ow"}, 64'(bp.overwrite_pc), 64'(exp_ow));
  endtask

  task automatic upd(input logic [63:0] pc,
                     input logic        taken);
    bp.update_valid = 1'b1;
    bp.update_pc    = pc;
    bp.update_taken = taken;
    @(posedge clk);
    #1;
    bp.update_valid = 1'b0;
  endtask

  initial begin
    n_vec           = 0;
    n_err           = 0;
    reset           = 1'b1;
    bp.pc           = '0;
    bp.instruction  = '0;
    bp.update_valid = 1'b0;
    bp.update_pc    = '0;
    bp.update_taken = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    pred("rst_jal", 64'h1000, I_JAL16, 64'h1004, 1'b0);
    reset = 1'b0;

    pred("jal", 64'h1000, I_JAL16, 64'h1010, 1'b1);
    pred("jal_wrap", 64'h0, I_JALM4,
         64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    pred("cold_br", 64'h2000, I_BEQM8, 64'h2004, 1'b0);

    upd(64'h2000, 1'b1);
    pred("ctr2", 64'h2000, I_BEQM8, 64'h1FF8, 1'b1);
    upd(64'h2000, 1'b1);
    pred("train", 64'h2000, I_BEQM8, 64'h1FF8, 1'b1);
    pred("alias", 64'h2100, I_BEQM8, 64'h20F8, 1'b1);
    pred("fwd_br", 64'h2000, I_BEQ16, 64'h2010, 1'b1);
    pred("other_idx", 64'h2004, I_BEQM8, 64'h2008, 1'b0);

    upd(64'h2000, 1'b1);
    upd(64'h2000, 1'b0);
    pred("sat3", 64'h2000, I_BEQM8, 64'h1FF8, 1'b1);

    bp.update_valid = 1'b1;
    bp.update_pc    = 64'h2000;
    bp.update_taken = 1'b0;
    pred("rbw", 64'h2000, I_BEQM8, 64'h1FF8, 1'b1);
    @(posedge clk);
    #1;
    bp.update_valid = 1'b0;
    pred("after_rbw", 64'h2000, I_BEQM8, 64'h2004, 1'b0);

    upd(64'h2000, 1'b0);
    upd(64'h2000, 1'b0);
    upd(64'h2000, 1'b1);
    pred("sat0", 64'h2000, I_BEQM8, 64'h2004, 1'b0);
    upd(64'h2000, 1'b1);
    pred("sat0_up", 64'h2000, I_BEQM8, 64'h1FF8, 1'b1);

    upd(64'h2000, 1'b1);
    reset           = 1'b1;
    bp.update_valid = 1'b1;
    bp.update_pc    = 64'h2000;
    bp.update_taken = 1'b1;
    pred("rst_out", 64'h2000, I_BEQM8, 64'h2004, 1'b0);
    @(posedge clk);
    #1;
    reset           = 1'b0;
    bp.update_valid = 1'b0;
    pred("rst_cold", 64'h2000, I_BEQM8, 64'h2004, 1'b0);
    upd(64'h2000, 1'b1);
    pred("rst_val01", 64'h2000, I_BEQM8, 64'h1FF8, 1'b1);

    pred("addi", 64'h3000, I_ADDI, 64'h3004, 1'b0);
    pred("bubble", 64'h3000, 32'h0, 64'h3004, 1'b0);
    pred("jalr", 64'h3000, I_JALR, 64'h3004, 1'b0);
    pred("pc_wrap", 64'hFFFF_FFFF_FFFF_FFFC, I_ADDI,
         64'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
